seq_gen_driver: RTL

Initiator for the sequence generator control protocol. It accepts calculation commands over a valid/ready interface and drives mode, order, data_in and the two-cycle load pulse to the generator. It then waits for done or error, captures data_out and status into a response, and issues a one-cycle clear. It sits between a command source (CPU-side queue or emulation transactor) and the generator.

---
 rtl/seq_gen_pkg.sv | 35 +++
 rtl/seq_gen_driver_if.sv | 42 ++++
 rtl/seq_gen_driver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types for the sequence generator driver: command modes, response
// status codes and the driver state encoding.
package seq_gen_pkg;

   localparam int ORDER_W = 16;
   localparam int DATA_W  = 64;

   typedef enum logic [1:0] {
      MODE_NONE = 2'b00,
      MODE_FIB  = 2'b01,
      MODE_TRI  = 2'b10,
      MODE_BAD  = 2'b11
   } seq_mode_t;

   typedef enum logic [1:0] {
      RSP_OK       = 2'd0,
      RSP_OVERFLOW = 2'd1,
      RSP_ERROR    = 2'd2,
      RSP_TIMEOUT  = 2'd3
   } rsp_status_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD1 = 3'd1,
      ST_LOAD2 = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4,
      ST_CLEAR = 3'd5
   } drv_state_e;

   function automatic logic mode_is_valid(input logic [1:0] mode);
      return (mode == MODE_FIB) || (mode == MODE_TRI);
   endfunction

endpackage

// File: rtl/seq_gen_driver_if.sv
// Command, generator and response signals of the sequence generator driver.
// The driver side is the master; the command source plus generator is the slave.
interface seq_gen_driver_if;
   import seq_gen_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_mode;
   logic [ORDER_W-1:0]   cmd_order;
   logic [DATA_W-1:0]    cmd_data_in;

   logic                 fibonacci;
   logic                 triangle;
   logic                 load;
   logic                 clear;
   logic [ORDER_W-1:0]   order;
   logic [DATA_W-1:0]    data_in;
   logic                 done;
   logic [DATA_W-1:0]    data_out;
   logic                 overflow;
   logic                 error;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_W-1:0]    rsp_data;
   logic [1:0]           rsp_status;

   modport master (
      input  cmd_valid, cmd_mode, cmd_order, cmd_data_in,
      input  done, data_out, overflow, error, rsp_ready,
      output cmd_ready, fibonacci, triangle, load, clear, order, data_in,
      output rsp_valid, rsp_data, rsp_status
   );

   modport slave (
      output cmd_valid, cmd_mode, cmd_order, cmd_data_in,
      output done, data_out, overflow, error, rsp_ready,
      input  cmd_ready, fibonacci, triangle, load, clear, order, data_in,
      input  rsp_valid, rsp_data, rsp_status
   );

endinterface

// File: rtl/seq_gen_driver.sv
// Initiator for the sequence generator: accepts a command, pulses load for two
// cycles, waits for done/error/timeout, returns a response, then pulses clear.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// LOAD1 | first load cycle, mode/order/data_in driven
// LOAD2 | second load cycle
// WAIT  | waiting for done or error, timeout counter running
// RESP  | response presented until rsp_ready
// CLEAR | one-cycle clear pulse to the generator
module seq_gen_driver
   import seq_gen_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   seq_gen_driver_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] S_LOAD1 = 3'(ST_LOAD1);
   localparam logic [2:0] S_LOAD2 = 3'(ST_LOAD2);
   localparam logic [2:0] S_WAIT  = 3'(ST_WAIT);
   localparam logic [2:0] S_RESP  = 3'(ST_RESP);
   localparam logic [2:0] S_CLEAR = 3'(ST_CLEAR);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]          state_q,      state_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic                fib_q,        fib_d;
   logic                tri_q,        tri_d;
   logic                load_q,       load_d;
   logic                clear_q,      clear_d;
   logic [ORDER_W-1:0]  order_q,      order_d;
   logic [DATA_W-1:0]   data_in_q,    data_in_d;
   logic                rsp_valid_q,  rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
   logic [1:0]          rsp_status_q, rsp_status_d;
   logic                sticky_q,     sticky_d;
   logic                loaded_q,     loaded_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fib_d        = fib_q;
      tri_d        = tri_q;
      load_d       = load_q;
      clear_d      = clear_q;
      order_d      = order_q;
      data_in_d    = data_in_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      sticky_d     = sticky_q;
      loaded_d     = loaded_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               sticky_d = 1'b0;
               cnt_d    = '0;
               if (mode_is_valid(bus.cmd_mode)) begin
                  order_d   = bus.cmd_order;
                  data_in_d = bus.cmd_data_in;
                  fib_d     = (bus.cmd_mode == MODE_FIB);
                  tri_d     = (bus.cmd_mode == MODE_TRI);
                  load_d    = 1'b1;
                  loaded_d  = 1'b1;
                  state_d   = S_LOAD1;
               end else begin
                  // Rejected without touching the generator, so no clear later.
                  loaded_d     = 1'b0;
                  rsp_valid_d  = 1'b1;
                  rsp_data_d   = '0;
                  rsp_status_d = RSP_ERROR;
                  state_d      = S_RESP;
               end
            end
         end
         S_LOAD1: begin
            if (bus.error || bus.done) sticky_d = 1'b1;
            state_d = S_LOAD2;
         end
         S_LOAD2: begin
            if (bus.error || bus.done) sticky_d = 1'b1;
            load_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.error || bus.done || (cnt_q == CNT_LAST)) begin
               if (bus.error) begin
                  rsp_data_d   = bus.done ? bus.data_out : '0;
                  rsp_status_d = RSP_ERROR;
               end else if (bus.done) begin
                  rsp_data_d   = bus.data_out;
                  rsp_status_d = sticky_q     ? RSP_ERROR    :
                                 bus.overflow ? RSP_OVERFLOW : RSP_OK;
               end else begin
                  rsp_data_d   = '0;
                  rsp_status_d = sticky_q ? RSP_ERROR : RSP_TIMEOUT;
               end
               cnt_d       = '0;
               fib_d       = 1'b0;
               tri_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (loaded_q) begin
                  clear_d = 1'b1;
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_CLEAR: begin
            clear_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         fib_q        <= 1'b0;
         tri_q        <= 1'b0;
         load_q       <= 1'b0;
         clear_q      <= 1'b0;
         order_q      <= '0;
         data_in_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= 2'd0;
         sticky_q     <= 1'b0;
         loaded_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fib_q        <= fib_d;
         tri_q        <= tri_d;
         load_q       <= load_d;
         clear_q      <= clear_d;
         order_q      <= order_d;
         data_in_q    <= data_in_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         sticky_q     <= sticky_d;
         loaded_q     <= loaded_d;
      end
   end

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign bus.fibonacci  = fib_q;
   assign bus.triangle   = tri_q;
   assign bus.load       = load_q;
   assign bus.clear      = clear_q;
   assign bus.order      = order_q;
   assign bus.data_in    = data_in_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_status = rsp_status_q;

endmodule
